// File: rtl/enc_pkg.sv
// Shared types and constants for the one-hot encoder pipeline.
package enc_pkg;

    localparam int ENC_IN_W  = 8;
    localparam int ENC_OUT_W = 3;

    // One encoded result: binary index plus the zero / multi-hot flags.
    typedef struct packed {
        logic [ENC_OUT_W-1:0] code;
        logic                 zero;
        logic                 multi;
    } enc_word_t;

endpackage

// File: rtl/onehot_enc_comb.sv
// Pure combinational one-hot to binary encoder with zero / multi-hot detection.
// MSB_FIRST selects which set bit wins when several are set.
module onehot_enc_comb
    import enc_pkg::*;
#(
    parameter int IN_W      = ENC_IN_W,
    parameter int OUT_W     = ENC_OUT_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [IN_W-1:0]  vec_i,
    output logic [OUT_W-1:0] code_o,
    output logic             zero_o,
    output logic             multi_o
);

    logic seenOne;

    // Detect whether no bit, or more than one bit, is set in the input vector.
    always_comb begin
        seenOne = 1'b0;
        multi_o = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (vec_i[i]) begin
                if (seenOne) begin
                    multi_o = 1'b1;
                end
                seenOne = 1'b1;
            end
        end
        zero_o = !seenOne;
    end

    generate
        if (MSB_FIRST) begin : gMsbFirst
            // Scan upward so the highest set bit is the last one written.
            always_comb begin
                code_o = '0;
                for (int i = 0; i < IN_W; i++) begin
                    if (vec_i[i]) begin
                        code_o = OUT_W'(i);
                    end
                end
            end
        end else begin : gLsbFirst
            // Scan downward so the lowest set bit is the last one written.
            always_comb begin
                code_o = '0;
                for (int i = IN_W - 1; i >= 0; i--) begin
                    if (vec_i[i]) begin
                        code_o = OUT_W'(i);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/encoder_8to3_pipe.sv
// Registered 8->3 one-hot encoder on a valid/ready stream.
// An output register plus one skid entry give full throughput while keeping
// in_ready a pure register output. Zero / multi-hot words are counted at
// acceptance in a saturating, clearable error counter.
module encoder_8to3_pipe
    import enc_pkg::*;
#(
    parameter int IN_W      = ENC_IN_W,
    parameter int OUT_W     = ENC_OUT_W,
    parameter bit MSB_FIRST = 1'b1,
    parameter int ERRCNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_vec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_code,
    output logic                out_zero,
    output logic                out_multi,
    output logic [ERRCNT_W-1:0] err_cnt,
    input  logic                err_cnt_clr
);

    generate
        if ((OUT_W != ENC_OUT_W) || (IN_W != (1 << OUT_W))) begin : gParamCheck
            $error("encoder_8to3_pipe: IN_W must be 2**OUT_W and OUT_W must match enc_pkg");
        end
    endgenerate

    logic [OUT_W-1:0]    encCode;
    logic                encZero;
    logic                encMulti;
    enc_word_t           newWord;

    enc_word_t           outWord_q,  outWord_d;
    logic                outValid_q, outValid_d;
    enc_word_t           skidWord_q, skidWord_d;
    logic                skidFull_q, skidFull_d;
    logic                inReady_q,  inReady_d;
    logic [ERRCNT_W-1:0] errCnt_q,   errCnt_d;

    logic                inFire;
    logic                outFire;

    onehot_enc_comb #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .MSB_FIRST (MSB_FIRST)
    ) uEnc (
        .vec_i   (in_vec),
        .code_o  (encCode),
        .zero_o  (encZero),
        .multi_o (encMulti)
    );

    assign inFire  = in_valid && inReady_q;
    assign outFire = outValid_q && out_ready;

    // Pack the encoder result into the word format shared by output and skid.
    always_comb begin
        newWord       = '0;
        newWord.code  = encCode;
        newWord.zero  = encZero;
        newWord.multi = encMulti;
    end

    // Next state of the two-entry buffer: output register refills from the skid
    // first (FIFO order), a stalled output diverts the incoming word to the skid.
    always_comb begin
        outWord_d  = outWord_q;
        outValid_d = outValid_q;
        skidWord_d = skidWord_q;
        skidFull_d = skidFull_q;
        if (!outValid_q || outFire) begin
            if (skidFull_q) begin
                outWord_d  = skidWord_q;
                outValid_d = 1'b1;
                if (inFire) begin
                    skidWord_d = newWord;
                end else begin
                    skidFull_d = 1'b0;
                end
            end else begin
                outValid_d = inFire;
                if (inFire) begin
                    outWord_d = newWord;
                end
            end
        end else if (inFire) begin
            skidWord_d = newWord;
            skidFull_d = 1'b1;
        end
        inReady_d = !skidFull_d;
    end

    // Next error count: clear has priority, otherwise count bad words until all-ones.
    always_comb begin
        errCnt_d = errCnt_q;
        if (err_cnt_clr) begin
            errCnt_d = '0;
        end else if (inFire && (newWord.zero || newWord.multi) && (errCnt_q != '1)) begin
            errCnt_d = errCnt_q + ERRCNT_W'(1);
        end
    end

    // Buffer registers; reset drops any held words and holds in_ready low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outWord_q  <= '0;
            outValid_q <= 1'b0;
            skidWord_q <= '0;
            skidFull_q <= 1'b0;
            inReady_q  <= 1'b0;
        end else begin
            outWord_q  <= outWord_d;
            outValid_q <= outValid_d;
            skidWord_q <= skidWord_d;
            skidFull_q <= skidFull_d;
            inReady_q  <= inReady_d;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCnt_q <= '0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_code  = outWord_q.code;
    assign out_zero  = outWord_q.zero;
    assign out_multi = outWord_q.multi;
    assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_encoder_8to3_pipe.sv
// Self-checking bench for encoder_8to3_pipe. The main instance uses the default
// parameters; a second instance (ERRCNT_W=2, MSB_FIRST=0) covers saturation and
// lowest-bit tie-break.
module tb_encoder_8to3_pipe;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;

    logic       inValid  = 1'b0;
    logic [7:0] inVec    = 8'h00;
    logic       outReady = 1'b1;
    logic       errClr   = 1'b0;
    logic       inReady, outValid, outZero, outMulti;
    logic [2:0] outCode;
    logic [7:0] errCnt;

    logic       inValid2  = 1'b0;
    logic [7:0] inVec2    = 8'h00;
    logic       outReady2 = 1'b1;
    logic       errClr2   = 1'b0;
    logic       inReady2, outValid2, outZero2, outMulti2;
    logic [2:0] outCode2;
    logic [1:0] errCnt2;

    int numTests  = 0;
    int numFailed = 0;

    typedef struct {
        logic [2:0] code;
        logic       zero;
        logic       multi;
    } refWord_t;

    always #5 clk = ~clk;

    encoder_8to3_pipe #(.IN_W(8), .OUT_W(3), .MSB_FIRST(1'b1), .ERRCNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid), .in_ready(inReady), .in_vec(inVec),
        .out_valid(outValid), .out_ready(outReady),
        .out_code(outCode), .out_zero(outZero), .out_multi(outMulti),
        .err_cnt(errCnt), .err_cnt_clr(errClr)
    );

    encoder_8to3_pipe #(.IN_W(8), .OUT_W(3), .MSB_FIRST(1'b0), .ERRCNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid2), .in_ready(inReady2), .in_vec(inVec2),
        .out_valid(outValid2), .out_ready(outReady2),
        .out_code(outCode2), .out_zero(outZero2), .out_multi(outMulti2),
        .err_cnt(errCnt2), .err_cnt_clr(errClr2)
    );

    // Reference encoding from arithmetic: highest set bit is clog2(x+1)-1,
    // lowest set bit is clog2 of the isolated lowest bit (x & -x).
    function automatic refWord_t refEncode(input logic [7:0] v, input bit msbFirst);
        refWord_t w;
        int x;
        x       = int'(v);
        w.zero  = (v == 8'h00);
        w.multi = ($countones(v) > 1);
        w.code  = 3'd0;
        if (x != 0) begin
            w.code = msbFirst ? 3'($clog2(x + 1) - 1) : 3'($clog2(x & -x));
        end
        return w;
    endfunction

    task automatic applyStimulus(input logic v, input logic [7:0] vec, input logic rdy, input logic clr);
        inValid  = v;
        inVec    = vec;
        outReady = rdy;
        errClr   = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        numTests++; if (outValid !== 1'b0) begin numFailed++; $display("[TB] FAIL reset out_valid: got %b want 0", outValid); end
        numTests++; if (outCode !== 3'd0) begin numFailed++; $display("[TB] FAIL reset out_code: got %0d want 0", outCode); end
        numTests++; if (outZero !== 1'b0) begin numFailed++; $display("[TB] FAIL reset out_zero: got %b want 0", outZero); end
        numTests++; if (outMulti !== 1'b0) begin numFailed++; $display("[TB] FAIL reset out_multi: got %b want 0", outMulti); end
        numTests++; if (errCnt !== 8'd0) begin numFailed++; $display("[TB] FAIL reset err_cnt: got %0d want 0", errCnt); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        numTests++; if (inReady !== 1'b1) begin numFailed++; $display("[TB] FAIL reset in_ready after release: got %b want 1", inReady); end
    endtask

    task automatic test_sweep();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 8'(1 << k), 1'b1, 1'b0);
            tick();
            numTests++; if (outValid !== 1'b1) begin numFailed++; $display("[TB] FAIL sweep out_valid k=%0d: got %b want 1", k, outValid); end
            numTests++; if (outCode !== 3'(k)) begin numFailed++; $display("[TB] FAIL sweep out_code k=%0d: got %0d want %0d", k, outCode, k); end
            numTests++; if ({outZero, outMulti} !== 2'b00) begin numFailed++; $display("[TB] FAIL sweep flags k=%0d: got %b want 00", k, {outZero, outMulti}); end
            numTests++; if (errCnt !== 8'd0) begin numFailed++; $display("[TB] FAIL sweep err_cnt k=%0d: got %0d want 0", k, errCnt); end
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        numTests++; if (outValid !== 1'b0) begin numFailed++; $display("[TB] FAIL sweep drain out_valid: got %b want 0", outValid); end
    endtask

    task automatic test_errors();
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
        tick();
        numTests++; if (outCode !== 3'd0) begin numFailed++; $display("[TB] FAIL zero out_code: got %0d want 0", outCode); end
        numTests++; if ({outZero, outMulti} !== 2'b10) begin numFailed++; $display("[TB] FAIL zero flags: got %b want 10", {outZero, outMulti}); end
        numTests++; if (errCnt !== 8'd1) begin numFailed++; $display("[TB] FAIL zero err_cnt: got %0d want 1", errCnt); end
        applyStimulus(1'b1, 8'h81, 1'b1, 1'b0);
        tick();
        numTests++; if (outCode !== 3'd7) begin numFailed++; $display("[TB] FAIL multi out_code: got %0d want 7", outCode); end
        numTests++; if ({outZero, outMulti} !== 2'b01) begin numFailed++; $display("[TB] FAIL multi flags: got %b want 01", {outZero, outMulti}); end
        numTests++; if (errCnt !== 8'd2) begin numFailed++; $display("[TB] FAIL multi err_cnt: got %0d want 2", errCnt); end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_backpressure();
        applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
        tick();
        numTests++; if (outValid !== 1'b1 || outCode !== 3'd2) begin numFailed++; $display("[TB] FAIL bp first word: got v=%b code=%0d want v=1 code=2", outValid, outCode); end
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
        tick();
        numTests++; if (inReady !== 1'b0) begin numFailed++; $display("[TB] FAIL bp in_ready after skid fill: got %b want 0", inReady); end
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            numTests++; if (inReady !== 1'b0) begin numFailed++; $display("[TB] FAIL bp hold in_ready cyc=%0d: got %b want 0", i, inReady); end
            numTests++; if (outValid !== 1'b1 || outCode !== 3'd2) begin numFailed++; $display("[TB] FAIL bp hold output cyc=%0d: got v=%b code=%0d want v=1 code=2", i, outValid, outCode); end
        end
        applyStimulus(1'b1, 8'h01, 1'b1, 1'b0);
        tick();
        numTests++; if (outValid !== 1'b1 || outCode !== 3'd5) begin numFailed++; $display("[TB] FAIL bp second word: got v=%b code=%0d want v=1 code=5", outValid, outCode); end
        numTests++; if (inReady !== 1'b1) begin numFailed++; $display("[TB] FAIL bp in_ready after release: got %b want 1", inReady); end
        tick();
        numTests++; if (outValid !== 1'b1 || outCode !== 3'd0) begin numFailed++; $display("[TB] FAIL bp third word: got v=%b code=%0d want v=1 code=0", outValid, outCode); end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        numTests++; if (outValid !== 1'b0) begin numFailed++; $display("[TB] FAIL bp drained out_valid: got %b want 0", outValid); end
    endtask

    task automatic test_random();
        refWord_t refQ[$];
        refWord_t w;
        int       errModel;
        int       sent;
        int       cycles;
        logic     vld;
        logic     rdy;
        logic     clr;
        logic [7:0] vec;
        bit       modelInFire;
        bit       modelOutFire;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        errModel = 0;
        sent     = 0;
        cycles   = 0;
        while ((sent < 1000 || refQ.size() > 0) && cycles < 20000) begin
            case ($urandom_range(0, 3))
                0, 1:    vec = 8'(1 << $urandom_range(0, 7));
                2:       vec = 8'($urandom);
                default: vec = 8'h00;
            endcase
            vld = (sent < 1000) && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 49) == 0);
            applyStimulus(vld, vec, rdy, clr);
            #3;
            numTests++; if (outValid !== (refQ.size() != 0)) begin numFailed++; $display("[TB] FAIL random out_valid cyc=%0d: got %b want %b", cycles, outValid, refQ.size() != 0); end
            numTests++; if (inReady !== (refQ.size() < 2)) begin numFailed++; $display("[TB] FAIL random in_ready cyc=%0d: got %b want %b", cycles, inReady, refQ.size() < 2); end
            numTests++; if (errCnt !== 8'(errModel)) begin numFailed++; $display("[TB] FAIL random err_cnt cyc=%0d: got %0d want %0d", cycles, errCnt, errModel); end
            if (refQ.size() > 0) begin
                numTests++;
                if (outCode !== refQ[0].code || outZero !== refQ[0].zero || outMulti !== refQ[0].multi) begin
                    numFailed++;
                    $display("[TB] FAIL random word cyc=%0d: got code=%0d z=%b m=%b want code=%0d z=%b m=%b",
                             cycles, outCode, outZero, outMulti, refQ[0].code, refQ[0].zero, refQ[0].multi);
                end
            end
            modelInFire  = vld && (refQ.size() < 2);
            modelOutFire = (refQ.size() > 0) && rdy;
            if (modelOutFire) begin
                void'(refQ.pop_front());
            end
            if (modelInFire) begin
                w = refEncode(vec, 1'b1);
                refQ.push_back(w);
                sent++;
            end
            if (clr) begin
                errModel = 0;
            end else if (modelInFire && (w.zero || w.multi) && errModel < 255) begin
                errModel++;
            end
            tick();
            cycles++;
        end
        numTests++; if (sent != 1000 || refQ.size() != 0) begin numFailed++; $display("[TB] FAIL random timeout: sent %0d pending %0d want 1000 and 0", sent, refQ.size()); end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_saturate();
        inValid2  = 1'b1;
        inVec2    = 8'h00;
        outReady2 = 1'b1;
        errClr2   = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            numTests++; if (errCnt2 !== 2'((i > 3) ? 3 : i)) begin numFailed++; $display("[TB] FAIL saturate err_cnt n=%0d: got %0d want %0d", i, errCnt2, (i > 3) ? 3 : i); end
        end
        inVec2 = 8'h81;
        tick();
        numTests++; if (outCode2 !== 3'd0 || outMulti2 !== 1'b1) begin numFailed++; $display("[TB] FAIL lsb 0x81: got code=%0d m=%b want code=0 m=1", outCode2, outMulti2); end
        numTests++; if (errCnt2 !== 2'd3) begin numFailed++; $display("[TB] FAIL saturate hold: got %0d want 3", errCnt2); end
        inVec2 = 8'h06;
        tick();
        numTests++; if (outCode2 !== 3'd1) begin numFailed++; $display("[TB] FAIL lsb 0x06: got code=%0d want 1", outCode2); end
        inVec2  = 8'h00;
        errClr2 = 1'b1;
        tick();
        numTests++; if (errCnt2 !== 2'd0) begin numFailed++; $display("[TB] FAIL clear beats increment: got %0d want 0", errCnt2); end
        errClr2 = 1'b0;
        inVec2  = 8'h81;
        tick();
        numTests++; if (errCnt2 !== 2'd1) begin numFailed++; $display("[TB] FAIL count after clear: got %0d want 1", errCnt2); end
        inValid2 = 1'b0;
        tick();
    endtask

    task automatic test_midreset();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        numTests++; if (inReady !== 1'b0 || outValid !== 1'b1) begin numFailed++; $display("[TB] FAIL midreset fill: got rdy=%b v=%b want rdy=0 v=1", inReady, outValid); end
        numTests++; if (errCnt !== 8'd2) begin numFailed++; $display("[TB] FAIL midreset err_cnt before: got %0d want 2", errCnt); end
        #2 rst_n = 1'b0;
        #1;
        numTests++; if (outValid !== 1'b0) begin numFailed++; $display("[TB] FAIL midreset async out_valid: got %b want 0", outValid); end
        numTests++; if (errCnt !== 8'd0) begin numFailed++; $display("[TB] FAIL midreset async err_cnt: got %0d want 0", errCnt); end
        numTests++; if (outZero !== 1'b0) begin numFailed++; $display("[TB] FAIL midreset async out_zero: got %b want 0", outZero); end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        numTests++; if (inReady !== 1'b1) begin numFailed++; $display("[TB] FAIL midreset in_ready after release: got %b want 1", inReady); end
        tick();
        numTests++; if (outValid !== 1'b0) begin numFailed++; $display("[TB] FAIL midreset no replay: got out_valid=%b want 0", outValid); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_errors();
        test_backpressure();
        test_random();
        test_saturate();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", numTests, numFailed);
        $finish;
    end

endmodule
